// File: rtl/weight_buf.sv
// weight_buf: captures 72-bit kernel words from the repacking FIFO and
// streams them in address order to the PE array under valid/ready
// handshaking, repeating the whole buffer for a programmable number of passes.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   load_start          pulse: begin a new load of load_len_m1+1 words
//   load_len_m1         load length minus one (latched on load_start)
//   wr_en/addr/data     write port driven by the repacking FIFO
//   rd_start            pulse: begin streaming (only honoured when loaded)
//   rd_passes           number of passes over the buffer, 0 means 1
//   rd_ready            PE array accepts rd_data this cycle
//   rd_valid, rd_data   streamed word
//   weights_ready       buffer holds a complete load and is idle
//   busy                filling or draining
//   done                one-cycle pulse after the final word is accepted
//   err                 sticky: a write arrived outside FILL
module weight_buf #(
  parameter int unsigned DW    = 72,
  parameter int unsigned AW    = 7,
  parameter int unsigned DEPTH = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [AW-1:0] load_len_m1,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_start,
  input  logic [3:0]    rd_passes,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          weights_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StFill   = 2'd1;
  localparam logic [1:0] StLoaded = 2'd2;
  localparam logic [1:0] StDrain  = 2'd3;

  localparam logic [AW:0] LenOne = 1;

  // Storage: deliberately not reset.
  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW:0]   len_q, len_d;          // 1..DEPTH, needs one extra bit
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    pass_cnt_q, pass_cnt_d;
  logic [3:0]    passes_q, passes_d;
  logic          fetch_done_q, fetch_done_d;  // every word of every pass fetched
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          mem_we;
  logic          fetch;
  logic          advance;
  logic          rd_last;
  logic          start_load;

  // load_start is ignored while draining.
  assign start_load = load_start && (state_q != StDrain);
  assign advance    = !rd_valid_q || rd_ready;
  assign rd_last    = ({1'b0, rd_ptr_q} == (len_q - LenOne));

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    wr_cnt_d     = wr_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    pass_cnt_d   = pass_cnt_q;
    passes_d     = passes_q;
    fetch_done_d = fetch_done_q;
    rd_valid_d   = rd_valid_q;
    done_d       = 1'b0;
    err_d        = err_q;
    mem_we       = 1'b0;
    fetch        = 1'b0;

    if (start_load) begin
      state_d  = StFill;
      len_d    = {1'b0, load_len_m1} + LenOne;
      wr_cnt_d = '0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StFill: begin
          if (wr_en) begin
            mem_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + LenOne;
            if ((wr_cnt_q + LenOne) == len_q) begin
              state_d = StLoaded;
            end
          end
        end
        StLoaded: begin
          if (rd_start) begin
            state_d      = StDrain;
            rd_ptr_d     = '0;
            pass_cnt_d   = '0;
            fetch_done_d = 1'b0;
            rd_valid_d   = 1'b0;
            passes_d     = (rd_passes == 4'd0) ? 4'd1 : rd_passes;
          end
        end
        StDrain: begin
          if (advance) begin
            if (!fetch_done_q) begin
              fetch      = 1'b1;
              rd_valid_d = 1'b1;
              if (rd_last) begin
                rd_ptr_d   = '0;
                pass_cnt_d = pass_cnt_q + 4'd1;
                if (pass_cnt_q == (passes_q - 4'd1)) begin
                  fetch_done_d = 1'b1;
                end
              end else begin
                rd_ptr_d = rd_ptr_q + 1'b1;
              end
            end else if (rd_valid_q) begin
              // Final word accepted: the stream is complete.
              rd_valid_d = 1'b0;
              done_d     = 1'b1;
              state_d    = StLoaded;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // A write outside FILL is dropped and flagged; this overrides the
    // clear from a coincident load_start in IDLE/LOADED.
    if (wr_en && (state_q != StFill)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      len_q        <= LenOne;
      wr_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      pass_cnt_q   <= '0;
      passes_q     <= 4'd1;
      fetch_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      pass_cnt_q   <= pass_cnt_d;
      passes_q     <= passes_d;
      fetch_done_q <= fetch_done_d;
      rd_valid_q   <= rd_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      if (fetch) begin
        rd_data_q <= mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign weights_ready = (state_q == StLoaded);
  assign busy          = (state_q == StFill) || (state_q == StDrain);
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_weight_buf.sv
// Self-checking bench for weight_buf: a cycle-by-cycle vector table for the
// basic load/drain, illegal-write and load/rd_start collision cases, then
// hand-written sequences for multi-pass, backpressure, reset mid-drain and
// full-depth operation.
module tb_weight_buf;

  localparam int DW = 72;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_len_m1 = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_start = 1'b0;
  logic [3:0]    rd_passes = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          weights_ready;
  logic          busy;
  logic          done;
  logic          err;

  weight_buf #(.DW(DW), .AW(AW), .DEPTH(128)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .load_len_m1   (load_len_m1),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_start      (rd_start),
    .rd_passes     (rd_passes),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .weights_ready (weights_ready),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ls;
    logic [AW-1:0] lm1;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rs;
    logic [3:0]    rp;
    logic          rr;
    logic          e_rv;
    logic [DW-1:0] e_rd;   // checked only when e_rv is 1
    logic          e_wr;
    logic          e_bz;
    logic          e_dn;
    logic          e_er;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam logic [DW-1:0] WA = 72'hA1A2A3A4A5A6A7A8A9;
  localparam logic [DW-1:0] WB = 72'hB1B2B3B4B5B6B7B8B9;
  localparam logic [DW-1:0] WC = 72'hC1C2C3C4C5C6C7C8C9;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ls, input logic [AW-1:0] lm1, input logic we,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic rs,
                     input logic [3:0] rp, input logic rr, input logic e_rv,
                     input logic [DW-1:0] e_rd, input logic e_wr, input logic e_bz,
                     input logic e_dn, input logic e_er);
    vec_t v;
    v.ls = ls; v.lm1 = lm1; v.we = we; v.wa = wa; v.wd = wd;
    v.rs = rs; v.rp = rp; v.rr = rr;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_wr = e_wr; v.e_bz = e_bz;
    v.e_dn = e_dn; v.e_er = e_er;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int len_m1, input int kind);
    load_start  = 1'b1;
    load_len_m1 = AW'(len_m1);
    tick();
    load_start = 1'b0;
    for (int i = 0; i <= len_m1; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = (kind == 0) ? DW'(i) : DW'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] abc [3];
    logic [DW-1:0] held_data;
    logic          acc_now, held;
    logic          pat [6];
    int            acc, seen_done;

    abc[0] = WA; abc[1] = WB; abc[2] = WC;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
    pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;

    // Basic load of 6 words and a single pass.
    add(1, 5, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 6; i++)
      add(0, 0, 1, AW'(i - 1), DW'(i), 0, 0, 0,   0, 0, (i == 6), (i != 6), 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1,   0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 6; i++)
      add(0, 0, 0, 0, 0, 0, 0, 1,   1, DW'(i), 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
    // Write in LOADED: dropped, err set; replay with passes=0 shows address 0 intact.
    add(0, 0, 1, 0, 72'hFF, 0, 0, 0,   0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 1, 0, 1);
    for (int i = 1; i <= 6; i++)
      add(0, 0, 0, 0, 0, 0, 0, 1,   1, DW'(i), 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 1, 1);
    // load_start and rd_start together: load wins, err cleared, no stream.
    add(1, 2, 0, 0, 0, 1, 1, 1,   0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, WA, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 1, WB, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 2, WC, 0, 0, 0,   0, 0, 1, 0, 0, 0);

    // Reset state.
    rst = 1'b0;
    tick();
    tick();
    check("reset_outputs", DW'({rd_valid, weights_ready, busy, done, err}), '0);
    check("reset_rd_data", rd_data, '0);
    rst = 1'b1;
    tick();

    foreach (vq[k]) begin
      load_start  = vq[k].ls;
      load_len_m1 = vq[k].lm1;
      wr_en       = vq[k].we;
      wr_addr     = vq[k].wa;
      wr_data     = vq[k].wd;
      rd_start    = vq[k].rs;
      rd_passes   = vq[k].rp;
      rd_ready    = vq[k].rr;
      tick();
      n_vec++;
      if ({rd_valid, weights_ready, busy, done, err} !==
          {vq[k].e_rv, vq[k].e_wr, vq[k].e_bz, vq[k].e_dn, vq[k].e_er} ||
          (vq[k].e_rv && rd_data !== vq[k].e_rd)) begin
        n_bad++;
        $display("FAIL vec%0d: got v/wr/bz/dn/er=%b%b%b%b%b data=%h, expected %b%b%b%b%b data=%h",
                 k, rd_valid, weights_ready, busy, done, err, rd_data,
                 vq[k].e_rv, vq[k].e_wr, vq[k].e_bz, vq[k].e_dn, vq[k].e_er, vq[k].e_rd);
      end
    end
    load_start = 1'b0; wr_en = 1'b0; rd_start = 1'b0;

    // Multi-pass: A B C x3 with no gaps.
    rd_start = 1'b1; rd_passes = 4'd3; rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    check("mp_start_busy", DW'({busy, rd_valid}), DW'(2'b10));
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("mp_word%0d", i), {rd_valid, rd_data}, {1'b1, abc[i % 3]});
    end
    tick();
    check("mp_done", DW'({done, rd_valid, busy, weights_ready}), DW'(4'b1001));
    tick();
    check("mp_done_once", DW'(done), '0);

    // Backpressure over a 6-word load.
    rd_ready = 1'b0;
    load(5, 1);
    check("bp_loaded", DW'(weights_ready), DW'(1));
    rd_start = 1'b1; rd_passes = 4'd1;
    tick();
    rd_start = 1'b0;
    acc = 0; seen_done = 0; held_data = '0;
    for (int c = 0; c < 60; c++) begin
      rd_ready  = pat[c % 6];
      acc_now   = rd_valid && rd_ready;
      held      = rd_valid && !rd_ready;
      held_data = rd_data;
      if (acc_now) begin
        check($sformatf("bp_accept%0d", acc), held_data, DW'(8'h10 + acc));
        acc++;
      end
      tick();
      if (held) check($sformatf("bp_hold_c%0d", c), {rd_valid, rd_data}, {1'b1, held_data});
      if (done) begin
        check("bp_done_after_6", DW'(acc), DW'(6));
        seen_done = 1;
        break;
      end
    end
    check("bp_done_seen", DW'(seen_done), DW'(1));
    rd_ready = 1'b0;
    tick();
    check("bp_done_once", DW'(done), '0);

    // Reset in the middle of a drain.
    rd_start = 1'b1; rd_passes = 4'd2; rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    tick();
    check("rst_pre_valid", DW'(rd_valid), DW'(1));
    rst = 1'b0;
    #1;
    check("rst_async_outputs", DW'({rd_valid, weights_ready, busy, done, err}), '0);
    check("rst_async_data", rd_data, '0);
    #1;
    rst = 1'b1;
    tick();
    check("rst_idle", DW'({weights_ready, busy, rd_valid}), '0);
    rd_start = 1'b1; rd_passes = 4'd1;
    tick();
    rd_start = 1'b0;
    check("rd_start_no_load", DW'({busy, rd_valid, weights_ready}), '0);
    tick();
    check("rd_start_no_load2", DW'({busy, rd_valid, done}), '0);

    // Full depth, passes=0 treated as one pass.
    rd_ready = 1'b0;
    load(127, 0);
    check("fd_loaded", DW'(weights_ready), DW'(1));
    rd_start = 1'b1; rd_passes = 4'd0; rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if ({rd_valid, rd_data} !== {1'b1, DW'(i)} || i == 0 || i == 127)
        check($sformatf("fd_word%0d", i), {rd_valid, rd_data}, {1'b1, DW'(i)});
    end
    tick();
    check("fd_done", DW'({done, rd_valid, weights_ready}), DW'(3'b101));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/weight_buf.md
# weight_buf

Weight buffer stage directly downstream of the 64-to-72-bit repacking FIFO. It captures the 72-bit words (one 3x3 kernel of nine 8-bit weights per word) that the FIFO writes, together with their 7-bit addresses. Once the programmed number of words has arrived, it streams them in address order to the PE array under a valid/ready handshake, for a programmable number of passes.

## Interface
- DW, 72, word width (nine 8-bit weights)
- AW, 7, address width
- DEPTH, 128, number of words (2^AW)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- load_start  in  1  one-cycle pulse that begins a new load
- load_len_m1  in  AW  number of words in the load, minus 1; latched on load_start
- wr_en  in  1  write strobe from the repacking FIFO
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- rd_start  in  1  one-cycle pulse that begins streaming
- rd_passes  in  4  number of passes over the buffer; 0 is treated as 1; latched on rd_start
- rd_ready  in  1  PE array accepts rd_data this cycle
- rd_valid  out  1  rd_data is valid
- rd_data  out  DW  streamed weight word
- weights_ready  out  1  high in LOADED
- busy  out  1  high in FILL or DRAIN
- done  out  1  one-cycle pulse after the last word of the last pass is accepted
- err  out  1  sticky flag for a write outside FILL; cleared by reset or load_start

## Operation
- Storage: DEPTH x DW array. The array is not reset.
- States and transitions:
  - IDLE: load_start -> FILL.
  - FILL: write count reaches len -> LOADED.
  - LOADED: load_start -> FILL. rd_start -> DRAIN.
  - DRAIN: last accept of the last pass -> LOADED.
- Length: len = load_len_m1 + 1, range 1..128.
- On load_start:
  - Latch len.
  - Clear wr_cnt (8 bits) and err.
- FILL:
  - Each wr_en writes mem[wr_addr] <= wr_data and increments wr_cnt.
  - When wr_cnt + 1 == len on a write, go to LOADED on the next edge.
  - Addresses are not checked. Duplicate addresses still count.
- wr_en in any state other than FILL:
  - The write is dropped.
  - err is set.
- DRAIN:
  - rd_ptr starts at 0 and pass_cnt at 0.
  - advance = !rd_valid || rd_ready. While the current pass has unfetched words, advance loads rd_data <= mem[rd_ptr] and sets rd_valid.
  - rd_ptr increments on each advance. When rd_ptr reaches len-1, it wraps to 0 and pass_cnt increments.
  - After the final word has been fetched, an accept (rd_valid && rd_ready) clears rd_valid.
  - The accept of the final word pulses done and returns the block to LOADED. The buffer contents are retained, so another rd_start replays them.
- Backpressure: when rd_valid && !rd_ready, rd_data, rd_ptr and pass_cnt hold.
- Simultaneous events:
  - load_start and rd_start together in LOADED: load_start wins.
  - load_start in FILL: restarts the load (count cleared, new len latched).
  - load_start in DRAIN: ignored.
  - rd_start outside LOADED: ignored.
  - wr_en on the same edge as load_start in IDLE or LOADED: dropped, and err is set.
- Reset, including mid-operation: state goes to IDLE and all outputs go to 0.

## Timing
- Reset values: rd_valid=0, rd_data=0, weights_ready=0, busy=0, done=0, err=0. Internally wr_cnt=0, rd_ptr=0, pass_cnt=0.
- Write latency: a wr_en at edge t makes the data readable from edge t+1.
- Fill completion: if the len-th write occurs at edge t, weights_ready is high from t+1.
- Drain start: rd_start sampled at edge t gives DRAIN at t+1, with the first rd_valid after edge t+1.
- Throughput: one word per cycle with rd_ready held high. With rd_ready=1 throughout, len*passes words take len*passes cycles from the first rd_valid.
- Completion: done is high for the cycle after the accept of the final word. weights_ready is high in that same cycle.

## Test plan
- Basic load and single pass:
  - Stimulus: load_start with load_len_m1=5, then 6 writes to addresses 0..5 with data 0x01..0x06, then rd_start with rd_passes=1 and rd_ready=1.
  - Response: weights_ready rises 1 cycle after the 6th write. rd_data is 0x01..0x06 on 6 consecutive cycles, then done pulses once.
- Multi-pass wrap:
  - Stimulus: len=3 holding A, B, C; rd_passes=3.
  - Response: the sequence A B C A B C A B C with no gaps, one done, busy low afterwards.
- Backpressure:
  - Stimulus: rd_ready toggled 1,0,0,1,0,1... during DRAIN.
  - Response: rd_data stable while rd_valid && !rd_ready, no word lost or duplicated, done only after the 6th accept.
- Illegal and simultaneous events:
  - Stimulus: wr_en in LOADED.
  - Response: memory unchanged and err=1.
  - Stimulus: load_start and rd_start on the same cycle.
  - Response: block enters FILL, err cleared, rd_valid stays 0.
- Reset mid-DRAIN:
  - Stimulus: drop rst while rd_valid=1 and mid-pass.
  - Response: all outputs 0 immediately, state IDLE.
  - Stimulus: rd_start with no load.
  - Response: ignored.
- Full depth:
  - Stimulus: load_len_m1=127, 128 writes with data equal to address, rd_passes=0.
  - Response: one pass of 128 words with values 0..127, then done.
